// File: rtl/pll_bringup_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_seq_pkg                                                          |
// | State encoding and default timing for the PLL bring-up sequencer.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_WAIT = 3'd1,
    ST_PROGRAM    = 3'd2,
    ST_PROG_WAIT  = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_LOCK_CHECK = 3'd5,
    ST_RUN        = 3'd6,
    ST_FAULT      = 3'd7
  } seq_state_t;

  localparam int unsigned c_start_delay   = 1024;
  localparam int unsigned c_ack_timeout   = 16;
  localparam int unsigned c_prog_timeout  = 2048;
  localparam int unsigned c_settle_cycles = 65536;
  localparam int unsigned c_lock_stable   = 1024;
  localparam int unsigned c_max_retries   = 3;
  localparam int unsigned c_cnt_w         = 17;

  function automatic logic [1:0] sat_inc2(input logic [1:0] val, input logic [1:0] lim);
    return (val >= lim) ? val : val + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_bringup_seq_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync2                                                                |
// | Two-flop synchroniser for asynchronous board pins.                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      q      <= '0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_bringup_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_bringup_seq                                                      |
// | Programs the clock synthesiser, waits for stable lock, releases DSP. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pll_bringup_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned START_DELAY   = c_start_delay,
  parameter int unsigned ACK_TIMEOUT   = c_ack_timeout,
  parameter int unsigned PROG_TIMEOUT  = c_prog_timeout,
  parameter int unsigned SETTLE_CYCLES = c_settle_cycles,
  parameter int unsigned LOCK_STABLE   = c_lock_stable,
  parameter int unsigned MAX_RETRIES   = c_max_retries,
  parameter int unsigned CNT_W         = c_cnt_w
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       prog_send,
  input  logic       prog_active,
  input  logic       pll_lock,
  output logic       dsp_reset_n,
  output logic       clk_good,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] c_start_last  = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] c_ack_last    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_prog_last   = CNT_W'(PROG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] c_dwell_last  = CNT_W'(4 * LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam logic [1:0]       c_max_retry   = 2'(MAX_RETRIES);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_stable;
  logic [1:0]       r_retry;
  logic             w_lock_s;
  logic             w_lock_ok;
  logic             w_fail;
  logic [1:0]       w_retry_next;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (w_lock_s)
  );

  // This cycle completes the required run of consecutive locked samples.
  assign w_lock_ok    = w_lock_s && (r_stable == c_stable_last);
  assign w_retry_next = sat_inc2(r_retry, c_max_retry);

  always_comb begin
    w_fail = 1'b0;
    case (r_state)
      ST_PROGRAM:    w_fail = !prog_active && (r_timer == c_ack_last);
      ST_PROG_WAIT:  w_fail = prog_active && (r_timer == c_prog_last);
      ST_LOCK_CHECK: w_fail = !w_lock_ok && (r_timer == c_dwell_last);
      ST_RUN:        w_fail = !w_lock_s;
      default:       w_fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_stable    <= '0;
      r_retry     <= '0;
      prog_send   <= 1'b0;
      dsp_reset_n <= 1'b0;
      clk_good    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      prog_send <= 1'b0;
      r_timer   <= r_timer + c_one;
      if (r_state != ST_FAULT && !enable) begin
        r_state     <= ST_IDLE;
        r_timer     <= '0;
        dsp_reset_n <= 1'b0;
        clk_good    <= 1'b0;
      end else if (w_fail) begin
        // The failing attempt is absorbed here rather than in its own state.
        r_retry     <= w_retry_next;
        r_timer     <= '0;
        dsp_reset_n <= 1'b0;
        clk_good    <= 1'b0;
        if (w_retry_next >= c_max_retry) begin
          r_state <= ST_FAULT;
          fault   <= 1'b1;
        end else begin
          r_state <= ST_START_WAIT;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_START_WAIT;
            r_timer <= '0;
          end
          ST_START_WAIT: begin
            if (r_timer == c_start_last) begin
              r_state   <= ST_PROGRAM;
              r_timer   <= '0;
              prog_send <= 1'b1;
            end
          end
          ST_PROGRAM: begin
            if (prog_active) begin
              r_state <= ST_PROG_WAIT;
              r_timer <= '0;
            end
          end
          ST_PROG_WAIT: begin
            if (!prog_active) begin
              r_state <= ST_SETTLE;
              r_timer <= '0;
            end
          end
          ST_SETTLE: begin
            if (r_timer == c_settle_last) begin
              r_state  <= ST_LOCK_CHECK;
              r_timer  <= '0;
              r_stable <= '0;
            end
          end
          ST_LOCK_CHECK: begin
            if (w_lock_ok) begin
              r_state     <= ST_RUN;
              r_timer     <= '0;
              clk_good    <= 1'b1;
              dsp_reset_n <= 1'b1;
            end else begin
              r_stable <= w_lock_s ? (r_stable + c_one) : '0;
            end
          end
          ST_RUN:   r_state <= ST_RUN;
          ST_FAULT: r_state <= ST_FAULT;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign retry_count = r_retry;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_bringup_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pll_bringup_seq                                                   |
// | Bench with programmer/PLL model, scenario table and scoreboard.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pll_bringup_seq;

  typedef struct {
    string name;
    int ack_never, ack_dly, busy_first, busy_rest, glitch_att, lock_level;
    int e_cg, e_dsp, e_flt, e_rty, e_st, e_sends, e_pg, e_lc;
  } row_t;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, prog_active = 1'b0, pll_lock = 1'b0;
  logic prog_send, dsp_reset_n, clk_good, fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  int checks = 0, errors = 0;
  int cfg_ack_never = 0, cfg_ack_dly = 2, cfg_busy_first = 20, cfg_busy_rest = 20;
  int cfg_glitch_att = 0, cfg_lock_level = 1;
  bit model_clr = 1'b1, lock_drop = 1'b0;
  int sends_seen = 0, pg_len = 0, lc_len = 0;

  row_t rows[5];
  row_t exp_q[$];

  pll_bringup_seq #(
    .START_DELAY(8), .ACK_TIMEOUT(4), .PROG_TIMEOUT(32), .SETTLE_CYCLES(16),
    .LOCK_STABLE(8), .MAX_RETRIES(3), .CNT_W(17)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .prog_send(prog_send),
    .prog_active(prog_active), .pll_lock(pll_lock), .dsp_reset_n(dsp_reset_n),
    .clk_good(clk_good), .fault(fault), .retry_count(retry_count), .state(state)
  );

  always #5 clk = ~clk;

  // Programmer and PLL model, plus first-dwell monitors, all on the falling edge.
  initial begin
    int wait_ack, busy, tick;
    bit ack_pending, prev_send, pg_done, lc_done;
    wait_ack = 0; busy = 0; tick = 0;
    ack_pending = 0; prev_send = 0; pg_done = 0; lc_done = 0;
    forever begin
      @(negedge clk);
      if (model_clr) begin
        sends_seen = 0; pg_len = 0; lc_len = 0; pg_done = 0; lc_done = 0;
        wait_ack = 0; busy = 0; tick = 0; ack_pending = 0; prev_send = 0;
        prog_active = 1'b0;
        pll_lock = cfg_lock_level[0];
      end else begin
        if (prog_send) begin
          checks++;
          if (prev_send) begin
            errors++;
            $display("FAIL prog_send_width: got 2 consecutive high cycles, expected 1");
          end
        end
        prev_send = prog_send;
        if (state == 3'd2 && !pg_done) pg_len++; else if (pg_len > 0) pg_done = 1;
        if (state == 3'd5 && !lc_done) lc_len++; else if (lc_len > 0) lc_done = 1;

        if (prog_send) begin
          sends_seen++;
          busy = 0;
          prog_active = 1'b0;
          ack_pending = (cfg_ack_never == 0);
          wait_ack = cfg_ack_dly;
        end else if (ack_pending) begin
          wait_ack--;
          if (wait_ack <= 0) begin
            ack_pending = 0;
            prog_active = 1'b1;
            busy = (sends_seen == 1) ? cfg_busy_first : cfg_busy_rest;
          end
        end else if (busy > 0) begin
          busy--;
          if (busy == 0) prog_active = 1'b0;
        end

        tick++;
        if (lock_drop) begin
          pll_lock = 1'b0;
          lock_drop = 1'b0;
        end else if (cfg_glitch_att > 0 && sends_seen <= cfg_glitch_att) begin
          pll_lock = ((tick / 5) % 2) == 0;
        end else begin
          pll_lock = cfg_lock_level[0];
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit cond_met(input int mode, input logic [2:0] st);
    case (mode)
      0:       return state == st;
      1:       return prog_send;
      2:       return clk_good || fault;
      3:       return !dsp_reset_n;
      default: return retry_count == st[1:0];
    endcase
  endfunction

  task automatic wait_cond(input string name, input int mode, input logic [2:0] st,
                           input int bound, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cond_met(mode, st)) return;
      if (cyc >= bound) begin
        checks++;
        errors++;
        $display("FAIL %s: got timeout after %0d cycles, expected event", name, cyc);
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    model_clr = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clr = 1'b0;
  endtask

  task automatic apply_cfg(input row_t r);
    cfg_ack_never = r.ack_never; cfg_ack_dly = r.ack_dly;
    cfg_busy_first = r.busy_first; cfg_busy_rest = r.busy_rest;
    cfg_glitch_att = r.glitch_att; cfg_lock_level = r.lock_level;
  endtask

  initial begin
    int cyc, len;
    row_t got;
    rows[0] = '{"nominal",      0, 2, 20, 20, 0, 1,  1, 1, 0, 0, 6, 1, 3, 8};
    rows[1] = '{"no_ack",       1, 2, 20, 20, 0, 1,  0, 0, 1, 3, 7, 3, 4, 0};
    rows[2] = '{"glitchy_lock", 0, 2, 20, 20, 1, 1,  1, 1, 0, 1, 6, 2, 3, 32};
    rows[3] = '{"prog_hang",    0, 2, 40, 20, 0, 1,  1, 1, 0, 1, 6, 2, 3, 8};
    rows[4] = '{"never_lock",   0, 2, 20, 20, 0, 0,  0, 0, 1, 3, 7, 3, 3, 32};

    // Reset values and idling with enable low
    apply_cfg(rows[0]);
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_prog_send", int'(prog_send), 0);
    chk("rst_dsp_reset_n", int'(dsp_reset_n), 0);
    chk("rst_clk_good", int'(clk_good), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_retry", int'(retry_count), 0);
    repeat (3) @(negedge clk);
    chk("idle_hold_state", int'(state), 0);

    // Nominal bring-up with timing of each phase
    enable = 1'b1;
    wait_cond("start_latency_wait", 1, 3'd0, 50, cyc);
    chk("start_latency", cyc, 9);
    wait_cond("settle_wait", 0, 3'd4, 200, cyc);
    len = 0;
    while (state == 3'd4 && len < 1000) begin len++; @(negedge clk); end
    chk("settle_dwell", len, 16);
    len = 0;
    while (state == 3'd5 && len < 1000) begin len++; @(negedge clk); end
    chk("lock_check_dwell", len, 8);
    chk("nom_state_run", int'(state), 6);
    chk("nom_clk_good", int'(clk_good), 1);
    chk("nom_dsp_reset_n", int'(dsp_reset_n), 1);

    // Single-cycle lock loss while running
    #1 lock_drop = 1'b1;
    wait_cond("lockloss_wait", 3, 3'd0, 10, cyc);
    checks++;
    if (cyc < 1 || cyc > 4) begin
      errors++;
      $display("FAIL lockloss_latency: got %0d cycles, expected 1..4", cyc);
    end
    chk("lockloss_clk_good", int'(clk_good), 0);
    chk("lockloss_state", int'(state), 1);
    chk("lockloss_retry", int'(retry_count), 1);
    wait_cond("reprogram_wait", 1, 3'd0, 100, cyc);
    wait_cond("rerun_wait", 2, 3'd0, 500, cyc);
    chk("rerun_state", int'(state), 6);
    chk("rerun_dsp_reset_n", int'(dsp_reset_n), 1);
    chk("rerun_retry", int'(retry_count), 1);

    // Disable while running
    enable = 1'b0;
    @(negedge clk);
    chk("disable_state", int'(state), 0);
    chk("disable_dsp_reset_n", int'(dsp_reset_n), 0);
    chk("disable_clk_good", int'(clk_good), 0);
    chk("disable_retry_held", int'(retry_count), 1);

    // Reset during the second attempt's programming phase
    apply_cfg(rows[3]);
    do_reset();
    enable = 1'b1;
    wait_cond("midrst_retry_wait", 4, 3'd1, 400, cyc);
    wait_cond("midrst_pw_wait", 0, 3'd3, 400, cyc);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", int'(state), 0);
    chk("midrst_prog_send", int'(prog_send), 0);
    chk("midrst_dsp_reset_n", int'(dsp_reset_n), 0);
    chk("midrst_clk_good", int'(clk_good), 0);
    chk("midrst_fault", int'(fault), 0);
    chk("midrst_retry", int'(retry_count), 0);

    // Scenario table, outcomes checked through the scoreboard queue
    for (int i = 0; i < 5; i++) begin
      apply_cfg(rows[i]);
      do_reset();
      chk({rows[i].name, "_rst_state"}, int'(state), 0);
      chk({rows[i].name, "_rst_fault"}, int'(fault), 0);
      chk({rows[i].name, "_rst_retry"}, int'(retry_count), 0);
      enable = 1'b1;
      exp_q.push_back(rows[i]);
      wait_cond({rows[i].name, "_end_wait"}, 2, 3'd0, 2000, cyc);
      repeat (20) @(negedge clk);
      got = exp_q.pop_front();
      chk({got.name, "_clk_good"}, int'(clk_good), got.e_cg);
      chk({got.name, "_dsp_reset_n"}, int'(dsp_reset_n), got.e_dsp);
      chk({got.name, "_fault"}, int'(fault), got.e_flt);
      chk({got.name, "_retry"}, int'(retry_count), got.e_rty);
      chk({got.name, "_state"}, int'(state), got.e_st);
      chk({got.name, "_sends"}, sends_seen, got.e_sends);
      chk({got.name, "_program_dwell"}, pg_len, got.e_pg);
      chk({got.name, "_lock_check_dwell"}, lc_len, got.e_lc);
      enable = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
